inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, reset value of the write-address counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  request accepted on the edge where in_valid&&in_ready.
REQ-006 in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6-7 invalid.
REQ-007 in_opcode, in_funct7  input  7 each; in_funct3  input  3; in_rd, in_rs1, in_rs2  input  5 each.
REQ-008 in_imm  input  32  immediate as signed byte value (branch/jump offsets unscaled).
REQ-009 out_valid  output  1; out_ready  input  1; pop on edge where out_valid&&out_ready.
REQ-010 out_inst  output  32  encoded instruction at FIFO head.
REQ-011 out_addr  output  32  instruction-memory byte address for head entry.
REQ-012 out_err  output  1  head entry failed encoding checks.
REQ-013 addr_load  input  1; addr_val  input  32  reload write-address counter.

Function
REQ-014 Fields: opcode->[6:0]; rd->[11:7] (R,I,U,J); funct3->[14:12] (R,I,S,B); rs1->[19:15] (R,I,S,B); rs2->[24:20] (R,S,B); funct7->[31:25] (R only); unused slots 0.
REQ-015 I: imm[11:0]->[31:20].  S: imm[11:5]->[31:25], imm[4:0]->[11:7].
REQ-016 B: imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7].
REQ-017 U: imm[31:12]->[31:12].  J: imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12].
REQ-018 Encoding is combinational from inputs and written into a 2-entry FIFO on accept; latency 1 cycle (out_valid high the cycle after accept when FIFO was empty).
REQ-019 FIFO states EMPTY/ONE/FULL; in_ready = (state != FULL); push-only advances, pop-only retreats, push+pop in ONE stays ONE.
REQ-020 FULL with pop: no push that cycle (in_ready low), state -> ONE.
REQ-021 Entries leave strictly in acceptance order; out_inst/out_err stable while out_valid&&!out_ready.
REQ-022 out_addr increments by 4 on each pop, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-023 addr_load loads {addr_val[31:2],2'b00} next edge, with priority over simultaneous pop increment; FIFO contents unaffected.
REQ-024 in_fmt 6-7: entry pushed with out_inst = 32'h0000_0013, out_err = 1 (both configurations).

Reset
REQ-025 While rst high at an edge: FIFO -> EMPTY, out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, in_ready=0 during reset cycle then 1.
REQ-026 Reset mid-operation discards all buffered entries; accepts and pops in a reset cycle are ignored.

Configuration
REQ-027 Macro IMM_RANGE_CHECK_EN.
REQ-028 Defined: I/S error if imm[31:11] not all equal; B error if imm[0]=1 or imm[31:12] not all equal; J error if imm[0]=1 or imm[31:20] not all equal; U error if imm[11:0]!=0; R never; errored entry stores 32'h0000_0013 with out_err=1.
REQ-029 Undefined: no range check, out-of-range bits silently truncated per REQ-015..017, out_err set only per REQ-024.

Verification
REQ-030 I, opcode 7'h13, rd=1, rs1=0, funct3=0, imm=5 -> out_inst 32'h0050_0093 one cycle later, out_err=0.
REQ-031 B, opcode 7'h63, rs1=1, rs2=2, funct3=0, imm=-8 -> 32'hFE20_8CE3; J, opcode 7'h6F, rd=1, imm=2048 -> 32'h0010_00EF.
REQ-032 out_ready=0, three back-to-back requests -> first two accepted, in_ready low on third; out_ready=1 -> three instructions drain in order.
REQ-033 addr_load with 32'h100, two pops -> out_addr 32'h100 then 32'h104; load 32'hFFFF_FFFC, pop -> 32'h0.
REQ-034 I, imm=4096 -> with IMM_RANGE_CHECK_EN: 32'h0000_0013, out_err=1; without: imm field 0, out_err=0; in_fmt=7 -> 32'h0000_0013, out_err=1.
REQ-035 rst asserted with FIFO FULL -> next cycle out_valid=0, out_addr=BASE_ADDR, in_ready=1.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: encodes RV32 instruction fields into a 2-entry output FIFO with address tagging; optional IMM_RANGE_CHECK_EN
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [6:0]  in_funct7,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  input  logic        addr_load,
  input  logic [31:0] addr_val
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t      r_state, w_next;
  logic [32:0] r_mem0, r_mem1;
  logic [31:0] r_addr, w_enc, w_inst;
  logic        w_push, w_pop, w_bad, w_rng;
  assign in_ready  = !rst && r_state != FULL;
  assign out_valid = r_state != EMPTY;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_err   = r_mem0[32];
  assign out_inst  = r_mem0[31:0];
  assign out_addr  = r_addr;
  assign w_enc = in_fmt == 3'd0 ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode} :
                 in_fmt == 3'd1 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
                 in_fmt == 3'd2 ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
                 in_fmt == 3'd3 ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode} :
                 in_fmt == 3'd4 ? {in_imm[31:12], in_rd, in_opcode} :
                 in_fmt == 3'd5 ? {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode} :
                 32'h0;
`ifdef IMM_RANGE_CHECK_EN
  assign w_rng = (in_fmt == 3'd1 || in_fmt == 3'd2) ? in_imm[31:11] != {21{in_imm[31]}} :
                 in_fmt == 3'd3 ? in_imm[0] || in_imm[31:12] != {20{in_imm[31]}} :
                 in_fmt == 3'd5 ? in_imm[0] || in_imm[31:20] != {12{in_imm[31]}} :
                 in_fmt == 3'd4 ? |in_imm[11:0] :
                 1'b0;
`else
  assign w_rng = 1'b0;
`endif
  assign w_bad  = in_fmt > 3'd5 || w_rng;
  assign w_inst = w_bad ? 32'h0000_0013 : w_enc;
  // FIFO occupancy register
  always_ff @(posedge clk)
    r_state <= rst ? EMPTY : w_next;
  // occupancy update: push-only fills, pop-only drains, push+pop holds
  always_comb begin
    w_next = r_state;
    if (w_push && !w_pop) w_next = r_state == EMPTY ? ONE : FULL;
    else if (w_pop && !w_push) w_next = r_state == FULL ? ONE : EMPTY;
  end
  // entry storage: slot 0 is always the head, slot 1 the entry behind it
  always_ff @(posedge clk)
    if (rst) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      if (w_push && (r_state == EMPTY || (r_state == ONE && w_pop))) r_mem0 <= {w_bad, w_inst};
      else if (w_pop && r_state == FULL) r_mem0 <= r_mem1;
      if (w_push && r_state == ONE && !w_pop) r_mem1 <= {w_bad, w_inst};
    end
  // head address: reload wins over the per-pop word step
  always_ff @(posedge clk)
    if (rst) r_addr <= BASE_ADDR;
    else if (addr_load) r_addr <= addr_val & ~32'h3;
    else if (w_pop) r_addr <= r_addr + 32'd4;
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed scoreboard bench for inst_encoder
module tb_inst_encoder;
  localparam logic [31:0] BASE = 32'h0000_0040;
  logic        clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, out_err, addr_load = 0;
  logic [2:0]  in_fmt = 0, in_funct3 = 0;
  logic [6:0]  in_opcode = 0, in_funct7 = 0;
  logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0, out_inst, out_addr, addr_val = 0;
  logic [32:0] sb[$];
  logic [32:0] e;
  int checks = 0, failures = 0, n_pops = 0;

  inst_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_funct7(in_funct7), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .addr_load(addr_load), .addr_val(addr_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // monitor: compare every popped head against the oldest expected entry
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_pop", out_inst, 32'hxxxx_xxxx);
      else begin
        e = sb.pop_front();
        chk("pop_inst", out_inst, e[31:0]);
        chk("pop_err", {31'd0, out_err}, {31'd0, e[32]});
      end
      n_pops++;
    end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    int n = 0;
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    else sb.push_back({ee, ei});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (out_valid && n < 50) begin n++; @(posedge clk); #1; end
    chk("drain_done", {31'd0, out_valid}, 32'd0);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_err", {31'd0, out_err}, 0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    rst = 0;
    #1 chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    step();
    out_ready = 1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 0);
    chk("latency_valid", {31'd0, out_valid}, 1);
    chk("latency_inst", out_inst, 32'h0050_0093);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE20_8CE3, 0);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF, 0);
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 32'h4031_00B3, 0);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 0);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 0);
    send(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0000_0013, 1);
`ifdef IMM_RANGE_CHECK_EN
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h0000_0013, 1);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0000_0013, 1);
`else
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h0000_0093, 0);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0020_8163, 0);
`endif
    drain();
    chk("addr_after_pops", out_addr, BASE + 32'(4 * n_pops));
    out_ready = 0;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1, 32'h0010_0113, 0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd2, 32'h0020_0193, 0);
    in_imm = 32'd3; in_rd = 5'd4; in_valid = 1;
    repeat (2) step();
    chk("full_in_ready", {31'd0, in_ready}, 0);
    chk("full_head_stable", out_inst, 32'h0010_0113);
    out_ready = 1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd3, 32'h0030_0213, 0);
    drain();
    out_ready = 0;
    addr_load = 1; addr_val = 32'h0000_0103;
    step();
    addr_load = 0;
    chk("addr_load", out_addr, 32'h0000_0100);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hABCD_E000, 32'hABCD_E0B7, 0);
    send(3'd4, 7'h17, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_1117, 0);
    chk("addr_hold", out_addr, 32'h0000_0100);
    out_ready = 1;
    step();
    chk("addr_pop1", out_addr, 32'h0000_0104);
    step();
    chk("addr_pop2", out_addr, 32'h0000_0108);
    out_ready = 0;
    addr_load = 1; addr_val = 32'hFFFF_FFFF;
    step();
    addr_load = 0;
    chk("addr_load_top", out_addr, 32'hFFFF_FFFC);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd7, 32'h0070_0293, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("addr_wrap", out_addr, 32'h0000_0000);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd9, 32'h0090_0313, 0);
    addr_load = 1; addr_val = 32'h0000_0200; out_ready = 1;
    step();
    addr_load = 0; out_ready = 0;
    chk("load_over_pop", out_addr, 32'h0000_0200);
    chk("load_pop_empty", {31'd0, out_valid}, 0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd1, 32'h0010_0393, 0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'd2, 32'h0020_0413, 0);
    chk("pre_rst_full", {31'd0, in_ready}, 0);
    rst = 1;
    step();
    sb.delete();
    chk("rst_full_valid", {31'd0, out_valid}, 0);
    chk("rst_full_addr", out_addr, BASE);
    rst = 0;
    #1 chk("rst_full_in_ready", {31'd0, in_ready}, 1);
    out_ready = 1;
    send(3'd0, 7'h33, 3'd7, 7'd0, 5'd9, 5'd10, 5'd11, 32'd0, 32'h00B5_74B3, 0);
    drain();
    chk("final_addr", out_addr, BASE + 32'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
